// File: rtl/moxie_wb_arbiter_if.sv
// Single Wishbone point-to-point link: one master side, one slave side.
// dat_w carries master-to-slave write data, dat_r slave-to-master read data.
interface moxie_wb_arbiter_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 16,
  parameter int SEL_WIDTH  = 2
);
  logic [ADDR_WIDTH-1:0] adr;
  logic [DATA_WIDTH-1:0] dat_w;
  logic [DATA_WIDTH-1:0] dat_r;
  logic [SEL_WIDTH-1:0]  sel;
  logic                  we;
  logic                  cyc;
  logic                  stb;
  logic                  ack;
  logic                  err;

  modport master (
    output adr, dat_w, sel, we, cyc, stb,
    input  dat_r, ack, err
  );

  modport slave (
    input  adr, dat_w, sel, we, cyc, stb,
    output dat_r, ack, err
  );
endinterface

// File: rtl/moxie_wb_arbiter.sv
// Two-master (fetch I, data D) round-robin Wishbone arbiter with whole-cycle
// ownership and a stalled-strobe watchdog that returns err to the owner.
module moxie_wb_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 16,
  parameter int SEL_WIDTH  = 2,
  parameter int TIMEOUT    = 255
) (
  input  logic               clk_i,
  input  logic               rst_i,
  moxie_wb_arbiter_if.slave  wb_I,
  moxie_wb_arbiter_if.slave  wb_D,
  moxie_wb_arbiter_if.master wb,
  output logic [1:0]         grant_o
);

  // Encoding chosen so the state register doubles as grant_o.
  localparam logic [1:0] IDLE    = 2'b00;
  localparam logic [1:0] GRANT_I = 2'b01;
  localparam logic [1:0] GRANT_D = 2'b10;

  localparam logic [7:0] TMO_LIMIT = 8'(TIMEOUT);

  logic [1:0] state_q, state_d;
  logic       last_d_q, last_d_d;   // 1: D held the most recent grant
  logic [7:0] tmo_cnt_q, tmo_cnt_d;

  logic own_i;
  logic own_d;
  logic own_cyc;
  logic own_stb;
  logic tmo_fire;
  logic unused_i_fields;

  assign own_i = (state_q == GRANT_I);
  assign own_d = (state_q == GRANT_D);

  // The fetch master is read-only; its write-side fields are never forwarded.
  assign unused_i_fields = ^{wb_I.dat_w, wb_I.sel, wb_I.we};

  // Owner-side request view, zero while idle.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    own_cyc = 1'b0;
    own_stb = 1'b0;
    if (own_i) begin
      own_cyc = wb_I.cyc;
      own_stb = wb_I.cyc & wb_I.stb;
    end else if (own_d) begin
      own_cyc = wb_D.cyc;
      own_stb = wb_D.cyc & wb_D.stb;
    end
  end

  // Downstream bus mux
  always_comb begin
    wb.adr   = {ADDR_WIDTH{1'b0}};
    wb.dat_w = {DATA_WIDTH{1'b0}};
    wb.sel   = {SEL_WIDTH{1'b0}};
    wb.we    = 1'b0;
    wb.cyc   = own_cyc;
    wb.stb   = own_stb;
    if (own_i) begin
      wb.adr = wb_I.adr;
      wb.sel = {SEL_WIDTH{1'b1}};
    end else if (own_d) begin
      wb.adr   = wb_D.adr;
      wb.dat_w = wb_D.dat_w;
      wb.sel   = wb_D.sel;
      wb.we    = wb_D.we;
    end
  end

  assign tmo_fire = own_stb & (tmo_cnt_q == TMO_LIMIT);

  // Responses reach only the owner and only while its strobe is up, which
  // also drops any late ack arriving after the owner released cyc.
  assign wb_I.dat_r = wb.dat_r;
  assign wb_D.dat_r = wb.dat_r;
  assign wb_I.ack   = own_i & own_stb & wb.ack;
  assign wb_D.ack   = own_d & own_stb & wb.ack;
  assign wb_I.err   = own_i & own_stb & (wb.err | tmo_fire);
  assign wb_D.err   = own_d & own_stb & (wb.err | tmo_fire);

  assign grant_o = state_q;

  always_comb begin
    tmo_cnt_d = 8'd0;
    if (own_stb && !wb.ack && !wb.err && !tmo_fire) begin
      tmo_cnt_d = tmo_cnt_q + 8'd1;
    end
  end

  always_comb begin
    state_d  = state_q;
    last_d_d = last_d_q;
    unique case (state_q)
      IDLE: begin
        if (wb_I.cyc && (!wb_D.cyc || last_d_q)) begin
          state_d  = GRANT_I;
          last_d_d = 1'b0;
        end else if (wb_D.cyc) begin
          state_d  = GRANT_D;
          last_d_d = 1'b1;
        end
      end
      GRANT_I: if (!wb_I.cyc) state_d = IDLE;
      GRANT_D: if (!wb_D.cyc) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
    if (rst_i) begin
      state_q   <= IDLE;
      last_d_q  <= 1'b1;
      tmo_cnt_q <= 8'd0;
    end else begin
      state_q   <= state_d;
      last_d_q  <= last_d_d;
      tmo_cnt_q <= tmo_cnt_d;
    end
  end

endmodule

// File: tb/tb_moxie_wb_arbiter.sv
// Self-checking bench for moxie_wb_arbiter: directed scenarios plus a
// randomized run compared against an owner/stall-count reference model.
module tb_moxie_wb_arbiter;

  localparam int AW  = 32;
  localparam int DW  = 16;
  localparam int SW  = 2;
  localparam int TMO = 255;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] grant;
  int         checks = 0;
  int         errors = 0;

  moxie_wb_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .SEL_WIDTH(SW)) wbi ();
  moxie_wb_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .SEL_WIDTH(SW)) wbd ();
  moxie_wb_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .SEL_WIDTH(SW)) wbs ();

  moxie_wb_arbiter #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .SEL_WIDTH(SW), .TIMEOUT(TMO)
  ) dut (
    .clk_i   (clk),
    .rst_i   (rst),
    .wb_I    (wbi),
    .wb_D    (wbd),
    .wb      (wbs),
    .grant_o (grant)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic idle_inputs();
    wbi.adr = '0; wbi.dat_w = '0; wbi.sel = '0; wbi.we = 1'b0; wbi.cyc = 1'b0; wbi.stb = 1'b0;
    wbd.adr = '0; wbd.dat_w = '0; wbd.sel = '0; wbd.we = 1'b0; wbd.cyc = 1'b0; wbd.stb = 1'b0;
    wbs.dat_r = '0; wbs.ack = 1'b0; wbs.err = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    wbi.cyc = 1'b1; wbi.stb = 1'b1; wbi.adr = 32'h1234;
    wbd.cyc = 1'b1; wbd.stb = 1'b1; wbd.adr = 32'h5678; wbd.we = 1'b1;
    wbs.ack = 1'b1; wbs.err = 1'b1;
    tick();
    tick();
    settle();
    checks++;
    if ({wbs.cyc, wbs.stb, wbs.we, wbs.sel, wbs.adr, wbs.dat_w, grant} !== '0) begin
      errors++;
      $display("FAIL reset_bus cyc=%b stb=%b we=%b sel=%b adr=%h dat=%h grant=%b expected all zero",
               wbs.cyc, wbs.stb, wbs.we, wbs.sel, wbs.adr, wbs.dat_w, grant);
    end
    checks++;
    if ({wbi.ack, wbi.err, wbd.ack, wbd.err} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_resp I ack/err=%b%b D ack/err=%b%b expected 0000",
               wbi.ack, wbi.err, wbd.ack, wbd.err);
    end
    idle_inputs();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_i_read();
    idle_inputs();
    wbi.adr = 32'h1000; wbi.cyc = 1'b1; wbi.stb = 1'b1;
    wbi.dat_w = 16'hFFFF; wbi.we = 1'b1; wbi.sel = 2'b00;
    settle();
    checks++;
    if (wbs.cyc !== 1'b0 || grant !== 2'b00) begin
      errors++;
      $display("FAIL i_read_latency cyc=%b grant=%b expected cyc=0 grant=00", wbs.cyc, grant);
    end
    tick();
    settle();
    checks++;
    if ({wbs.cyc, wbs.stb, wbs.adr, wbs.we, wbs.sel, wbs.dat_w, grant} !==
        {1'b1, 1'b1, 32'h1000, 1'b0, 2'b11, 16'h0000, 2'b01}) begin
      errors++;
      $display("FAIL i_read_bus cyc=%b stb=%b adr=%h we=%b sel=%b dat=%h grant=%b expected 1 1 00001000 0 11 0000 01",
               wbs.cyc, wbs.stb, wbs.adr, wbs.we, wbs.sel, wbs.dat_w, grant);
    end
    wbs.ack = 1'b1; wbs.dat_r = 16'hBEEF;
    settle();
    checks++;
    if ({wbi.ack, wbi.err, wbi.dat_r, wbd.ack, wbd.dat_r} !== {1'b1, 1'b0, 16'hBEEF, 1'b0, 16'hBEEF}) begin
      errors++;
      $display("FAIL i_read_ack I ack=%b err=%b dat=%h D ack=%b dat=%h expected 1 0 beef 0 beef",
               wbi.ack, wbi.err, wbi.dat_r, wbd.ack, wbd.dat_r);
    end
    tick();
    wbi.cyc = 1'b0; wbi.stb = 1'b0;
    settle();
    checks++;
    if (wbi.ack !== 1'b0 || wbs.cyc !== 1'b0) begin
      errors++;
      $display("FAIL i_read_late_ack I ack=%b cyc_o=%b expected 0 0", wbi.ack, wbs.cyc);
    end
    wbs.ack = 1'b0;
    tick();
    settle();
    checks++;
    if (grant !== 2'b00) begin
      errors++;
      $display("FAIL i_read_release grant=%b expected 00", grant);
    end
    tick();
  endtask

  task automatic test_d_write();
    idle_inputs();
    wbd.adr = 32'h2002; wbd.dat_w = 16'h55AA; wbd.sel = 2'b01; wbd.we = 1'b1;
    wbd.cyc = 1'b1; wbd.stb = 1'b1;
    tick();
    settle();
    checks++;
    if ({wbs.cyc, wbs.stb, wbs.adr, wbs.dat_w, wbs.sel, wbs.we, grant} !==
        {1'b1, 1'b1, 32'h2002, 16'h55AA, 2'b01, 1'b1, 2'b10}) begin
      errors++;
      $display("FAIL d_write_bus cyc=%b stb=%b adr=%h dat=%h sel=%b we=%b grant=%b expected 1 1 00002002 55aa 01 1 10",
               wbs.cyc, wbs.stb, wbs.adr, wbs.dat_w, wbs.sel, wbs.we, grant);
    end
    wbs.ack = 1'b1;
    settle();
    checks++;
    if ({wbd.ack, wbi.ack} !== 2'b10) begin
      errors++;
      $display("FAIL d_write_ack D ack=%b I ack=%b expected 1 0", wbd.ack, wbi.ack);
    end
    tick();
    idle_inputs();
    tick();
    tick();
  endtask

  task automatic test_contention();
    logic [1:0] exp_g;
    do_reset();
    wbi.cyc = 1'b1; wbi.stb = 1'b1; wbi.adr = 32'h0100;
    wbd.cyc = 1'b1; wbd.stb = 1'b1; wbd.adr = 32'h0200;
    for (int n = 0; n < 4; n++) begin
      exp_g = (n % 2 == 0) ? 2'b01 : 2'b10;
      settle();
      checks++;
      if (wbs.cyc !== 1'b0 || grant !== 2'b00) begin
        errors++;
        $display("FAIL contention_idle_%0d cyc=%b grant=%b expected 0 00", n, wbs.cyc, grant);
      end
      tick();
      settle();
      checks++;
      if (grant !== exp_g || wbs.cyc !== 1'b1) begin
        errors++;
        $display("FAIL contention_grant_%0d grant=%b cyc=%b expected %b 1", n, grant, wbs.cyc, exp_g);
      end
      wbs.ack = 1'b1;
      settle();
      checks++;
      if ({wbi.ack, wbd.ack} !== ((exp_g == 2'b01) ? 2'b10 : 2'b01)) begin
        errors++;
        $display("FAIL contention_ack_%0d I ack=%b D ack=%b owner=%b", n, wbi.ack, wbd.ack, exp_g);
      end
      tick();
      wbs.ack = 1'b0;
      if (exp_g == 2'b01) begin wbi.cyc = 1'b0; wbi.stb = 1'b0; end
      else begin wbd.cyc = 1'b0; wbd.stb = 1'b0; end
      tick();
      if (n < 3) begin
        if (exp_g == 2'b01) begin wbi.cyc = 1'b1; wbi.stb = 1'b1; end
        else begin wbd.cyc = 1'b1; wbd.stb = 1'b1; end
      end else begin
        idle_inputs();
      end
    end
    tick();
  endtask

  task automatic test_burst_lock();
    idle_inputs();
    wbd.cyc = 1'b1; wbd.stb = 1'b1; wbd.adr = 32'h3000; wbd.sel = 2'b11;
    tick();
    wbi.cyc = 1'b1; wbi.stb = 1'b1; wbi.adr = 32'h4000;
    for (int b = 0; b < 5; b++) begin
      wbs.ack = (b != 2);
      settle();
      checks++;
      if (grant !== 2'b10 || wbd.ack !== wbs.ack || wbi.ack !== 1'b0 || wbs.adr !== 32'h3000) begin
        errors++;
        $display("FAIL burst_beat_%0d grant=%b D ack=%b I ack=%b adr=%h expected 10 %b 0 00003000",
                 b, grant, wbd.ack, wbi.ack, wbs.adr, wbs.ack);
      end
      tick();
    end
    wbs.ack = 1'b0; wbd.cyc = 1'b0; wbd.stb = 1'b0;
    settle();
    checks++;
    if (grant !== 2'b10 || wbs.cyc !== 1'b0) begin
      errors++;
      $display("FAIL burst_drop grant=%b cyc=%b expected 10 0", grant, wbs.cyc);
    end
    tick();
    settle();
    checks++;
    if (grant !== 2'b00 || wbs.cyc !== 1'b0) begin
      errors++;
      $display("FAIL burst_gap grant=%b cyc=%b expected 00 0", grant, wbs.cyc);
    end
    tick();
    settle();
    checks++;
    if (grant !== 2'b01 || wbs.cyc !== 1'b1 || wbs.adr !== 32'h4000) begin
      errors++;
      $display("FAIL burst_handover grant=%b cyc=%b adr=%h expected 01 1 00004000", grant, wbs.cyc, wbs.adr);
    end
    idle_inputs();
    tick();
    tick();
  endtask

  task automatic test_timeout();
    logic exp_err;
    idle_inputs();
    wbi.cyc = 1'b1; wbi.stb = 1'b1; wbi.adr = 32'h5000;
    tick();
    // k counts cycles with stb_o high; a bus err coincides with the second expiry
    for (int k = 1; k <= 514; k++) begin
      wbs.err = (k == 512);
      settle();
      exp_err = (k == TMO + 1) || (k == 2 * (TMO + 1));
      checks++;
      if (wbi.err !== exp_err || wbd.err !== 1'b0 || wbs.stb !== 1'b1) begin
        errors++;
        $display("FAIL timeout_cycle_%0d I err=%b D err=%b stb=%b expected %b 0 1",
                 k, wbi.err, wbd.err, wbs.stb, exp_err);
      end
      tick();
    end
    idle_inputs();
    tick();
    tick();
  endtask

  task automatic test_reset_mid();
    idle_inputs();
    wbd.cyc = 1'b1; wbd.stb = 1'b1; wbd.adr = 32'h6000;
    tick();
    settle();
    checks++;
    if (grant !== 2'b10 || wbs.stb !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid_pre grant=%b stb=%b expected 10 1", grant, wbs.stb);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    wbi.cyc = 1'b1; wbi.stb = 1'b1; wbi.adr = 32'h7000;
    settle();
    checks++;
    if (wbs.cyc !== 1'b0 || wbs.stb !== 1'b0 || grant !== 2'b00) begin
      errors++;
      $display("FAIL reset_mid_abort cyc=%b stb=%b grant=%b expected 0 0 00", wbs.cyc, wbs.stb, grant);
    end
    tick();
    settle();
    checks++;
    if (grant !== 2'b01 || wbs.adr !== 32'h7000) begin
      errors++;
      $display("FAIL reset_mid_first grant=%b adr=%h expected 01 00007000", grant, wbs.adr);
    end
    idle_inputs();
    tick();
    tick();
  endtask

  task automatic test_random();
    int owner;   // 0 none, 1 fetch, 2 data
    int last;
    int stall;
    logic o_cyc, o_stb, fire;
    logic [90:0] exp_v, act_v;
    logic [AW-1:0] e_adr;
    logic [DW-1:0] e_dat;
    logic [SW-1:0] e_sel;
    logic e_we;
    logic [1:0] e_grant;
    do_reset();
    owner = 0; last = 2; stall = 0;
    for (int c = 0; c < 3000; c++) begin
      if (wbi.cyc) begin if ($urandom_range(3) == 0) wbi.cyc = 1'b0; end
      else if ($urandom_range(2) == 0) wbi.cyc = 1'b1;
      if (wbd.cyc) begin if ($urandom_range(3) == 0) wbd.cyc = 1'b0; end
      else if ($urandom_range(2) == 0) wbd.cyc = 1'b1;
      wbi.stb = wbi.cyc & ($urandom_range(3) != 0);
      wbd.stb = wbd.cyc & ($urandom_range(3) != 0);
      wbi.adr = $urandom; wbi.dat_w = 16'($urandom); wbi.sel = 2'($urandom); wbi.we = 1'($urandom);
      wbd.adr = $urandom; wbd.dat_w = 16'($urandom); wbd.sel = 2'($urandom); wbd.we = 1'($urandom);
      wbs.ack = ($urandom_range(2) == 0);
      wbs.err = ($urandom_range(9) == 0);
      wbs.dat_r = 16'($urandom);
      settle();

      o_cyc = (owner == 1) ? wbi.cyc : (owner == 2) ? wbd.cyc : 1'b0;
      o_stb = (owner == 1) ? wbi.stb : (owner == 2) ? wbd.stb : 1'b0;
      fire  = o_stb && (stall == TMO);
      e_adr = (owner == 1) ? wbi.adr : (owner == 2) ? wbd.adr : '0;
      e_dat = (owner == 2) ? wbd.dat_w : '0;
      e_sel = (owner == 1) ? 2'b11 : (owner == 2) ? wbd.sel : 2'b00;
      e_we  = (owner == 2) ? wbd.we : 1'b0;
      e_grant = (owner == 1) ? 2'b01 : (owner == 2) ? 2'b10 : 2'b00;
      exp_v = {o_cyc, o_stb, e_we, e_sel, e_adr, e_dat, e_grant,
               (owner == 1) && o_stb && wbs.ack, (owner == 1) && o_stb && (wbs.err || fire),
               (owner == 2) && o_stb && wbs.ack, (owner == 2) && o_stb && (wbs.err || fire),
               wbs.dat_r, wbs.dat_r};
      act_v = {wbs.cyc, wbs.stb, wbs.we, wbs.sel, wbs.adr, wbs.dat_w, grant,
               wbi.ack, wbi.err, wbd.ack, wbd.err, wbi.dat_r, wbd.dat_r};
      checks++;
      if (act_v !== exp_v) begin
        errors++;
        $display("FAIL random_cycle_%0d got=%h expected=%h owner=%0d stall=%0d", c, act_v, exp_v, owner, stall);
      end

      if (o_stb && !wbs.ack && !wbs.err && !fire) stall++;
      else stall = 0;
      if (owner == 0) begin
        if (wbi.cyc && wbd.cyc) owner = (last == 1) ? 2 : 1;
        else if (wbi.cyc) owner = 1;
        else if (wbd.cyc) owner = 2;
        if (owner != 0) last = owner;
      end else if (!o_cyc) begin
        owner = 0;
      end
      tick();
    end
    idle_inputs();
    tick();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation did not finish within time limit");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    idle_inputs();
    test_reset();
    test_i_read();
    test_d_write();
    test_contention();
    test_burst_lock();
    test_timeout();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/moxie_wb_arbiter.md
Name: moxie_wb_arbiter

Overview:
Registered two-master Wishbone arbiter that sits directly downstream of the moxie core. It takes the core's instruction-fetch master (I) and data-memory master (D) and drives the single external 16-bit Wishbone bus.
- Ownership is held for a whole Wishbone cycle, so multi-beat fetches and loads/stores are never interleaved.
- Round-robin grant prevents either master from starving the other.
- A bus-timeout watchdog returns an error to the owning master.

Parameters:
ADDR_WIDTH, 32, address width of all buses
DATA_WIDTH, 16, data width of all buses
SEL_WIDTH, 2, byte-select width (DATA_WIDTH/8)
TIMEOUT, 255, cycles with stb_o high and no ack/err before err is returned to the owner (8-bit counter, 1..255)

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous active-high reset
wb_I_adr_i  in  ADDR_WIDTH  fetch address
wb_I_cyc_i  in  1  fetch cycle
wb_I_stb_i  in  1  fetch strobe
wb_I_dat_o  out  DATA_WIDTH  fetch read data
wb_I_ack_o  out  1  fetch ack
wb_I_err_o  out  1  fetch error
wb_D_adr_i  in  ADDR_WIDTH  data address
wb_D_dat_i  in  DATA_WIDTH  write data
wb_D_sel_i  in  SEL_WIDTH  byte selects
wb_D_we_i  in  1  write enable
wb_D_cyc_i  in  1  data cycle
wb_D_stb_i  in  1  data strobe
wb_D_dat_o  out  DATA_WIDTH  data read data
wb_D_ack_o  out  1  data ack
wb_D_err_o  out  1  data error
wb_adr_o  out  ADDR_WIDTH  bus address
wb_dat_o  out  DATA_WIDTH  bus write data
wb_sel_o  out  SEL_WIDTH  bus byte selects
wb_we_o  out  1  bus write enable
wb_cyc_o  out  1  bus cycle
wb_stb_o  out  1  bus strobe
wb_dat_i  in  DATA_WIDTH  bus read data
wb_ack_i  in  1  bus ack
wb_err_i  in  1  bus error
grant_o  out  2  owner status: 2'b01 = I, 2'b10 = D, 2'b00 = idle

Behaviour:
- Clock and reset: one clock, clk_i. Reset is synchronous and active-high on rst_i, sampled at the rising edge of clk_i.
- Reset values:
  - state = IDLE, last_grant = D (so I wins the first contention), timeout counter = 0.
  - All bus outputs 0, all master ack/err 0, grant_o = 0.
- States:
  - IDLE: no owner; all wb_*_o are 0.
  - GRANT_I: I owns the bus.
  - GRANT_D: D owns the bus.
- IDLE arbitration (decided on the clock edge, takes effect next cycle):
  - Only I_cyc high -> GRANT_I. Only D_cyc high -> GRANT_D.
  - Both high -> grant the master that is not last_grant.
  - last_grant updates on entry to a GRANT state.
  - Arbitration latency: exactly 1 cycle from master cyc to wb_cyc_o.
- GRANT_x:
  - wb_cyc_o and wb_stb_o follow the owner's cyc/stb combinationally.
  - adr/dat/sel/we are muxed from the owner.
  - Owner I: wb_we_o = 0, wb_sel_o = all ones, wb_dat_o = 0.
  - Stay in GRANT_x while the owner's cyc is high (burst lock), even if the other master is requesting.
  - When the owner's cyc is low, return to IDLE. There is always at least one cycle with wb_cyc_o = 0 between owners.
- Response routing:
  - wb_I_dat_o and wb_D_dat_o both equal wb_dat_i (broadcast).
  - ack/err go only to the owner, and only when the owner's stb is high.
  - The non-owner, and both masters in IDLE, see ack = err = 0.
  - A late ack arriving after the owner drops cyc is discarded.
- Timeout:
  - Counter increments each cycle in GRANT with wb_stb_o = 1 and wb_ack_i = wb_err_i = 0.
  - Cleared on ack, err, stb low, or leaving GRANT.
  - When count reaches TIMEOUT (cycle TIMEOUT+1 of the stall), assert owner err for exactly 1 cycle and clear the counter.
  - wb_stb_o is not forced low; the owner is expected to drop stb/cyc.
- Simultaneous events:
  - wb_ack_i and wb_err_i together: both are forwarded.
  - Bus err and timeout in the same cycle: a single err pulse.
- Reset mid-transaction:
  - Reset sampled high at an edge -> state IDLE from that edge.
  - wb_cyc_o/wb_stb_o are 0 in the following cycle regardless of master inputs; the in-flight transfer is abandoned.
  - Returns to reset values as above.
- Widths: no arithmetic on data or address. The timeout counter saturates only via its clear; it never wraps past TIMEOUT.

Test Plan:
- I-only read: I_cyc = I_stb = 1, adr 0x1000. Required: next cycle wb_cyc_o = 1, wb_adr_o = 0x1000, wb_we_o = 0, wb_sel_o = 2'b11. Slave acks with 0xBEEF -> wb_I_ack_o = 1, wb_I_dat_o = 0xBEEF, wb_D_ack_o = 0.
- D-only write: adr 0x2002, dat 0x55AA, sel 2'b01, we = 1. Required: bus shows exactly these values one cycle later; ack reaches D only; grant_o = 2'b10.
- Contention: I and D both raise cyc in the same cycle right after reset, each doing 1-beat transfers repeatedly. Required grant order I, D, I, D, with one IDLE cycle (wb_cyc_o = 0) between grants.
- Burst lock: D holds cyc for 4 acked beats while I requests throughout. Required: grant_o stays 2'b10 for all 4 beats; I is granted only after D drops cyc plus 1 idle cycle.
- Timeout: I granted, slave never acks, TIMEOUT = 255. Required: wb_I_err_o pulses for one cycle, on the 256th cycle of stb high, and counter restarts.
- Reset mid-cycle: rst_i high for one edge while D is granted with stb high. Required: wb_cyc_o = 0 and grant_o = 0 the next cycle. A following simultaneous I/D request grants I first.
